// File: rtl/b12_pkg.sv
// b12_pkg: shared definitions for the b12 autoplayer.
//   - state_e         : autoplayer FSM states
//   - RED..BLUE       : 2-bit colour codes used in the sequence store
//   - WIN_LEDS        : nl pattern the game shows after a won game
//   - colour_to_onehot / onehot_to_colour / is_onehot4 : LED/key encode helpers
package b12_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StListen,
      StPress,
      StRelease,
      StWinWait,
      StEnd
   } state_e;

   localparam logic [1:0] RED    = 2'd0;
   localparam logic [1:0] GREEN  = 2'd1;
   localparam logic [1:0] YELLOW = 2'd2;
   localparam logic [1:0] BLUE   = 2'd3;

   localparam logic [3:0] WIN_LEDS = 4'hF;

   function automatic logic [3:0] colour_to_onehot(input logic [1:0] c);
      return 4'b0001 << c;
   endfunction

   // Only meaningful for one-hot inputs; anything else decodes to RED.
   function automatic logic [1:0] onehot_to_colour(input logic [3:0] v);
      logic [1:0] c;
      case (v)
         4'b0010: c = GREEN;
         4'b0100: c = YELLOW;
         4'b1000: c = BLUE;
         default: c = RED;
      endcase
      return c;
   endfunction

   function automatic logic is_onehot4(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

endpackage

// File: rtl/b12_autoplayer_if.sv
// b12_autoplayer_if: player-side bus between the autoplayer and the b12 game.
//   go     : request to start a game           (env  -> player)
//   nl     : game LEDs, one-hot colour or 4'hF (game -> player)
//   nloss  : game loss LED, active-high        (game -> player)
//   start  : one-cycle start pulse             (player -> game)
//   k      : one-hot key press                 (player -> game)
//   round  : current round, 0 in idle          (player -> env)
//   done/won/lost/fault : sticky outcome flags (player -> env)
// master = autoplayer side, slave = game/environment side.
interface b12_autoplayer_if;

   logic       go;
   logic [3:0] nl;
   logic       nloss;
   logic       start;
   logic [3:0] k;
   logic [5:0] round;
   logic       done;
   logic       won;
   logic       lost;
   logic       fault;

   modport master (
      input  go, nl, nloss,
      output start, k, round, done, won, lost, fault
   );

   modport slave (
      output go, nl, nloss,
      input  start, k, round, done, won, lost, fault
   );

endinterface

// File: rtl/b12_seq_store.sv
// b12_seq_store: 32 x 2-bit colour register file, synchronous write, combinational read.
//   clock   : write clock
//   i_we    : write enable
//   i_idx   : shared read/write index
//   i_wdata : colour code to store
//   o_rdata : colour code at i_idx
// Contents are undefined after reset; the autoplayer always writes before it reads.
module b12_seq_store (
   input  logic       clock,
   input  logic       i_we,
   input  logic [4:0] i_idx,
   input  logic [1:0] i_wdata,
   output logic [1:0] o_rdata
);

   logic [1:0] r_mem [32];

   always_ff @(posedge clock) begin
      if (i_we) begin
         r_mem[i_idx] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/b12_autoplayer.sv
// b12_autoplayer: closed-loop player for the b12 memory game.
// Each round it records the colours the game flashes on nl, replays them as one-hot key
// presses on k (waiting for the game's echo and release of each), and finally reports
// won / lost / fault.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   ap    : b12_autoplayer_if.master (go, nl, nloss in; start, k, round, flags out)
// Parameters: MAX_ROUNDS (rounds per game, <= 32), WDOG_CYCLES (max wait for an nl event,
// <= 255), ERR_ROUND (round with an injected wrong key; exists only with the macro).
// Build option: define B12_AUTOPLAYER_ERR_INJECT_EN to press a wrong colour on the first
// key of round ERR_ROUND, so the game is expected to end lost in that round.
module b12_autoplayer
   import b12_pkg::*;
#(
   parameter int unsigned MAX_ROUNDS  = 32,
`ifdef B12_AUTOPLAYER_ERR_INJECT_EN
   parameter int unsigned ERR_ROUND   = 3,
`endif
   parameter int unsigned WDOG_CYCLES = 255
) (
   input logic              clock,
   input logic              reset,
   b12_autoplayer_if.master ap
);

   localparam logic [5:0] LastRound = 6'(MAX_ROUNDS);
   localparam logic [7:0] WdogLimit = 8'(WDOG_CYCLES);

   state_e     r_state;
   logic [5:0] r_round;
   logic [4:0] r_idx;
   logic [7:0] r_wdog;
   logic [3:0] r_nl_prev;
   logic       r_start;
   logic [3:0] r_k;
   logic       r_won;
   logic       r_lost;
   logic       r_fault;
   logic       r_done;

   logic       w_busy;
   logic       w_nl_onehot;
   logic       w_capture;
   logic       w_wdog_exp;
   logic       w_nl_bad;
   logic [1:0] w_nl_colour;
   logic [1:0] w_rd_colour;
   logic [1:0] w_key_colour;
   logic [3:0] w_key;

   assign w_busy      = (r_state != StIdle) && (r_state != StEnd);
   assign w_nl_onehot = is_onehot4(ap.nl);
   assign w_nl_colour = onehot_to_colour(ap.nl);
   // A capture is a rising event: LEDs were dark last cycle and show one colour now.
   assign w_capture   = (r_state == StListen) && (r_nl_prev == 4'd0) && w_nl_onehot;
   assign w_nl_bad    = (r_state == StListen) && (ap.nl != 4'd0) && !w_nl_onehot;
   // The count starts at 0 on the first waiting cycle, so reaching the limit means the
   // wait has lasted longer than WDOG_CYCLES cycles.
   assign w_wdog_exp  = (r_wdog >= WdogLimit);

`ifdef B12_AUTOPLAYER_ERR_INJECT_EN
   localparam logic [5:0] ErrRound = 6'(ERR_ROUND);
   assign w_key_colour = ((r_round == ErrRound) && (r_idx == 5'd0)) ? w_rd_colour + 2'd1
                                                                     : w_rd_colour;
`else
   assign w_key_colour = w_rd_colour;
`endif

   assign w_key = colour_to_onehot(w_key_colour);

   b12_seq_store u_seq_store (
      .clock   (clock),
      .i_we    (w_capture),
      .i_idx   (r_idx),
      .i_wdata (w_nl_colour),
      .o_rdata (w_rd_colour)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state   <= StIdle;
         r_round   <= 6'd0;
         r_idx     <= 5'd0;
         r_wdog    <= 8'd0;
         r_nl_prev <= 4'd0;
         r_start   <= 1'b0;
         r_k       <= 4'd0;
         r_won     <= 1'b0;
         r_lost    <= 1'b0;
         r_fault   <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_nl_prev <= ap.nl;
         r_start   <= 1'b0;
         r_k       <= 4'd0;
         r_wdog    <= w_busy ? r_wdog + 8'd1 : 8'd0;

         if (w_busy && ap.nloss) begin
            r_lost  <= 1'b1;
            r_done  <= 1'b1;
            r_wdog  <= 8'd0;
            r_state <= StEnd;
         end else if (w_busy && w_wdog_exp) begin
            r_fault <= 1'b1;
            r_done  <= 1'b1;
            r_wdog  <= 8'd0;
            r_state <= StEnd;
         end else if (w_nl_bad) begin
            r_fault <= 1'b1;
            r_done  <= 1'b1;
            r_wdog  <= 8'd0;
            r_state <= StEnd;
         end else begin
            unique case (r_state)
               StIdle: begin
                  if (ap.go) begin
                     r_start <= 1'b1;
                     r_state <= StStart;
                  end
               end
               StStart: begin
                  r_round <= 6'd1;
                  r_idx   <= 5'd0;
                  r_wdog  <= 8'd0;
                  r_state <= StListen;
               end
               StListen: begin
                  if (w_capture) begin
                     r_wdog <= 8'd0;
                     if (({1'b0, r_idx} + 6'd1) == r_round) begin
                        r_idx   <= 5'd0;
                        r_state <= StPress;
                     end else begin
                        r_idx <= r_idx + 5'd1;
                     end
                  end
               end
               StPress: begin
                  // The game echoes a pressed key on nl; that ends the press.
                  if (ap.nl == w_key) begin
                     r_wdog  <= 8'd0;
                     r_state <= StRelease;
                  end else begin
                     r_k <= w_key;
                  end
               end
               StRelease: begin
                  if (ap.nl == 4'd0) begin
                     r_wdog <= 8'd0;
                     if ({1'b0, r_idx} < (r_round - 6'd1)) begin
                        r_idx   <= r_idx + 5'd1;
                        r_state <= StPress;
                     end else if (r_round < LastRound) begin
                        r_round <= r_round + 6'd1;
                        r_idx   <= 5'd0;
                        r_state <= StListen;
                     end else begin
                        r_state <= StWinWait;
                     end
                  end
               end
               StWinWait: begin
                  if (ap.nl == WIN_LEDS) begin
                     r_won   <= 1'b1;
                     r_done  <= 1'b1;
                     r_wdog  <= 8'd0;
                     r_state <= StEnd;
                  end
               end
               StEnd: begin
                  if (ap.go) begin
                     r_won   <= 1'b0;
                     r_lost  <= 1'b0;
                     r_fault <= 1'b0;
                     r_done  <= 1'b0;
                     r_start <= 1'b1;
                     r_state <= StStart;
                  end
               end
               default: r_state <= StIdle;
            endcase
         end
      end
   end

   assign ap.start = r_start;
   assign ap.k     = r_k;
   assign ap.round = r_round;
   assign ap.done  = r_done;
   assign ap.won   = r_won;
   assign ap.lost  = r_lost;
   assign ap.fault = r_fault;

endmodule
